// File: rtl/kernel_control_regs.sv
// AXI4-Lite ap_ctrl-style control/argument register block driving the kernel go/done handshake.
// Optional interrupt registers (GIE/IER/ISR) are built when KERNEL_CTRL_IRQ_EN is defined.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | kernel idle; ap_idle=1, waiting for a host ap_start write
// ST_GO    | go_valid asserted, waiting for the action to drop holdoff
// ST_RUN   | action running; done_stop released, waiting for done_valid
module kernel_control_regs #(
  parameter int NUM_ARGS = 4,
  parameter int DEC_BITS = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              s_axi_araddr,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [31:0]              s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  input  logic [31:0]              s_axi_awaddr,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [31:0]              s_axi_wdata,
  input  logic [3:0]               s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  output logic                     action_go_valid,
  input  logic                     action_go_holdoff,
  input  logic                     action_done_valid,
  output logic                     action_done_stop,
  output logic [32*NUM_ARGS-1:0]   kernel_args,
  output logic                     interrupt
);

  localparam int IW = DEC_BITS - 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GO   = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic          wr_pulse;
  logic          rd_pulse;
  logic [IW-1:0] wi;
  logic [IW-1:0] ri;
  logic          wr_ctrl;
  logic          wr_gie;
  logic          wr_ier;
  logic          wr_isr;
  logic          rd_ctrl;
  logic          start_req;
  logic          go_acc;
  logic          done_take;
  logic          idle;
  logic          ap_start;
  logic          ap_done;
  logic          ap_ready;
  logic          gie;
  logic          ier;
  logic          isr;
  logic [31:0]   rd_word;
  logic [31:0]   args [NUM_ARGS];
  logic          unused_addr;

  assign wi = s_axi_awaddr[DEC_BITS-1:2];
  assign ri = s_axi_araddr[DEC_BITS-1:2];
  assign unused_addr = ^{s_axi_awaddr[31:DEC_BITS], s_axi_awaddr[1:0],
                         s_axi_araddr[31:DEC_BITS], s_axi_araddr[1:0]};

  assign wr_pulse = s_axi_awready;
  assign rd_pulse = s_axi_arready;

  // Control registers react only to the low byte lane.
  assign wr_ctrl = wr_pulse && s_axi_wstrb[0] && (wi == IW'(0));
  assign wr_gie  = wr_pulse && s_axi_wstrb[0] && (wi == IW'(1));
  assign wr_ier  = wr_pulse && s_axi_wstrb[0] && (wi == IW'(2));
  assign wr_isr  = wr_pulse && s_axi_wstrb[0] && (wi == IW'(3));
  assign rd_ctrl = rd_pulse && (ri == IW'(0));

  assign start_req = wr_ctrl && s_axi_wdata[0];
  assign idle      = (state == ST_IDLE);

  assign s_axi_rresp = 2'b00;
  assign s_axi_bresp = 2'b00;

  // Write channel: one transaction outstanding, ready pulse then held bvalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
    end else begin
      if (s_axi_awready) begin
        s_axi_awready <= 1'b0;
        s_axi_wready  <= 1'b0;
        s_axi_bvalid  <= 1'b1;
      end else if (s_axi_bvalid) begin
        if (s_axi_bready) begin
          s_axi_bvalid <= 1'b0;
        end
      end else if (s_axi_awvalid && s_axi_wvalid) begin
        s_axi_awready <= 1'b1;
        s_axi_wready  <= 1'b1;
      end
    end
  end

  // Read channel: data is latched on the arready pulse, rvalid held until rready.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= 32'd0;
    end else begin
      if (s_axi_arready) begin
        s_axi_arready <= 1'b0;
        s_axi_rvalid  <= 1'b1;
        s_axi_rdata   <= rd_word;
      end else if (s_axi_rvalid) begin
        if (s_axi_rready) begin
          s_axi_rvalid <= 1'b0;
        end
      end else if (s_axi_arvalid) begin
        s_axi_arready <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_word = 32'd0;
    if (ri == IW'(0)) begin
      // A done captured on this very cycle is already visible to the read.
      rd_word = {28'd0, ap_ready, idle, ap_done | done_take, ap_start};
    end else if (ri == IW'(1)) begin
      rd_word = {31'd0, gie};
    end else if (ri == IW'(2)) begin
      rd_word = {31'd0, ier};
    end else if (ri == IW'(3)) begin
      rd_word = {31'd0, isr};
    end
    for (int i = 0; i < NUM_ARGS; i++) begin
      if (int'(ri) == 4 + i) begin
        rd_word = args[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    action_go_valid  = 1'b0;
    action_done_stop = 1'b1;
    go_acc           = 1'b0;
    done_take        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_req) begin
          state_nxt = ST_GO;
        end
      end
      ST_GO: begin
        action_go_valid = 1'b1;
        if (!action_go_holdoff) begin
          go_acc    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        action_done_stop = 1'b0;
        if (action_done_valid) begin
          done_take = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Set of ap_done wins over the clear-on-read so a coincident completion is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      ap_start <= 1'b0;
      ap_done  <= 1'b0;
      ap_ready <= 1'b0;
    end else begin
      ap_ready <= go_acc;
      if (go_acc) begin
        ap_start <= 1'b0;
      end else if (idle && start_req) begin
        ap_start <= 1'b1;
      end
      if (done_take) begin
        ap_done <= 1'b1;
      end else if (rd_ctrl) begin
        ap_done <= 1'b0;
      end
    end
  end

  // Arguments are frozen outside IDLE so the action sees stable values for the run.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ARGS; i++) begin
        args[i] <= 32'd0;
      end
    end else if (wr_pulse && idle) begin
      for (int i = 0; i < NUM_ARGS; i++) begin
        if (int'(wi) == 4 + i) begin
          for (int b = 0; b < 4; b++) begin
            if (s_axi_wstrb[b]) begin
              args[i][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_ARGS; g++) begin : g_args
    assign kernel_args[32*g +: 32] = args[g];
  end

`ifdef KERNEL_CTRL_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      gie <= 1'b0;
      ier <= 1'b0;
      isr <= 1'b0;
    end else begin
      if (wr_gie) begin
        gie <= s_axi_wdata[0];
      end
      if (wr_ier) begin
        ier <= s_axi_wdata[0];
      end
      isr <= (isr ^ (wr_isr & s_axi_wdata[0])) | (done_take & ier);
    end
  end

  assign interrupt = gie & isr & ier;
`else
  logic unused_irq_wr;

  assign gie           = 1'b0;
  assign ier           = 1'b0;
  assign isr           = 1'b0;
  assign interrupt     = 1'b0;
  assign unused_irq_wr = wr_gie ^ wr_ier ^ wr_isr;
`endif

endmodule

// File: tb/tb_kernel_control_regs.sv
// Scoreboard bench for kernel_control_regs: read expectations are queued at issue
// and checked when the read data handshake completes.
module tb_kernel_control_regs;

  localparam int NUM_ARGS = 4;
`ifdef KERNEL_CTRL_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic [31:0]            araddr = '0;
  logic                   arvalid = 1'b0;
  logic                   arready;
  logic [31:0]            rdata;
  logic [1:0]             rresp;
  logic                   rvalid;
  logic                   rready = 1'b0;
  logic [31:0]            awaddr = '0;
  logic                   awvalid = 1'b0;
  logic                   awready;
  logic [31:0]            wdata = '0;
  logic [3:0]             wstrb = '0;
  logic                   wvalid = 1'b0;
  logic                   wready;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready = 1'b0;
  logic                   go_valid;
  logic                   holdoff = 1'b0;
  logic                   done_valid = 1'b0;
  logic                   done_stop;
  logic [32*NUM_ARGS-1:0] kargs;
  logic                   irq;

  int total = 0;
  int bad = 0;
  int go_count = 0;
  logic [31:0] exp_q [$];
  string tag_q [$];
  logic [32*NUM_ARGS-1:0] exp_args = '0;

  kernel_control_regs #(.NUM_ARGS(NUM_ARGS), .DEC_BITS(8)) dut (
    .clk(clk), .reset(reset),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .action_go_valid(go_valid), .action_go_holdoff(holdoff),
    .action_done_valid(done_valid), .action_done_stop(done_stop),
    .kernel_args(kargs), .interrupt(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!reset && go_valid && !holdoff) go_count++;
  end

  always @(negedge clk) begin
    if (rvalid && rready) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 1, 0);
      end else begin
        chk(tag_q.pop_front(), rdata, exp_q.pop_front());
        chk("rresp", rresp, 0);
      end
    end
  end

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag,
                    input bit done_at_pulse = 1'b0);
    int n;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk); #1 araddr = addr; arvalid = 1'b1;
    if (done_at_pulse) begin
      @(posedge clk); #1 done_valid = 1'b1;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 20);
    if (!arready) chk({tag, "_arready_timeout"}, 0, 1);
    @(posedge clk); #1 arvalid = 1'b0; done_valid = 1'b0; rready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 20);
    if (!rvalid) begin
      chk({tag, "_rvalid_timeout"}, 0, 1);
      void'(exp_q.pop_front());
      void'(tag_q.pop_front());
    end
    @(posedge clk); #1 rready = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input int bhold, input string tag);
    int n;
    @(posedge clk); #1 awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 20);
    if (!awready) chk({tag, "_awready_timeout"}, 0, 1);
    chk({tag, "_wready"}, wready, 1);
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < bhold; i++) begin
      @(negedge clk);
      chk({tag, "_bvalid_held"}, bvalid, 1);
    end
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    if (!bvalid) chk({tag, "_bvalid_timeout"}, 0, 1);
    chk({tag, "_bresp"}, bresp, 0);
    @(posedge clk); #1 bready = 1'b0;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 done_valid = 1'b1;
    @(posedge clk); #1 done_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_awready", awready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_go_valid", go_valid, 0);
    chk("rst_done_stop", done_stop, 1);
    chk("rst_irq", irq, 0);
    chk("rst_args", kargs, exp_args);

    rd(32'h00, 32'h4, "ctrl_idle");
    rd(32'h40, 32'h0, "unmapped");

    wr(32'h10, 32'hDEADBEEF, 4'b0011, 3, "arg0");
    exp_args[31:0] = 32'h0000BEEF;
    chk("arg0_strb", kargs, exp_args);
    wr(32'h14, 32'hCAFEF00D, 4'b1100, 0, "arg1");
    exp_args[63:32] = 32'hCAFE0000;
    chk("arg1_strb", kargs, exp_args);
    rd(32'h10, 32'h0000BEEF, "arg0_rd");
    rd(32'h14, 32'hCAFE0000, "arg1_rd");

    wr(32'h00, 32'h1, 4'b0010, 0, "ctrl_nostrb");
    @(negedge clk);
    chk("nostrb_go", go_valid, 0);
    rd(32'h00, 32'h4, "ctrl_nostrb_rd");

    wr(32'h04, 32'h1, 4'b0001, 0, "gie");
    wr(32'h08, 32'h1, 4'b0001, 0, "ier");
    rd(32'h04, {31'd0, IRQ}, "gie_rd");

    holdoff = 1'b1;
    wr(32'h00, 32'h1, 4'b0001, 0, "start1");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("go_held", go_valid, 1);
      chk("go_held_stop", done_stop, 1);
    end
    chk("go_cnt_held", go_count, 0);
    @(posedge clk); #1 holdoff = 1'b0;
    @(negedge clk);
    chk("go_accept_cycle", go_valid, 1);
    @(negedge clk);
    chk("go_dropped", go_valid, 0);
    chk("run_done_stop", done_stop, 0);
    chk("go_cnt1", go_count, 1);
    rd(32'h00, 32'h0, "ctrl_run");

    wr(32'h10, 32'h12345678, 4'b1111, 0, "arg0_run");
    chk("args_frozen", kargs, exp_args);
    wr(32'h00, 32'h1, 4'b0001, 0, "start_run");
    repeat (3) @(negedge clk);
    chk("run_no_go", go_valid, 0);
    chk("go_cnt_run", go_count, 1);
    rd(32'h00, 32'h0, "ctrl_run2");

    pulse_done();
    @(negedge clk);
    chk("idle_done_stop", done_stop, 1);
    chk("irq_set", irq, IRQ);
    rd(32'h00, 32'h6, "ctrl_done");
    rd(32'h00, 32'h4, "ctrl_cleared");
    rd(32'h0C, {31'd0, IRQ}, "isr_rd");
    wr(32'h0C, 32'h1, 4'b0001, 0, "isr_toggle");
    @(negedge clk);
    chk("irq_clear", irq, 0);
    rd(32'h0C, 32'h0, "isr_rd_clr");

    wr(32'h00, 32'h1, 4'b0001, 0, "start2");
    repeat (3) @(negedge clk);
    chk("go_cnt2", go_count, 2);
    chk("run2_done_stop", done_stop, 0);
    rd(32'h00, 32'h2, "ctrl_simul", 1'b1);
    rd(32'h00, 32'h6, "ctrl_kept");
    rd(32'h00, 32'h4, "ctrl_after_kept");

    wr(32'h00, 32'h1, 4'b0001, 0, "start3");
    repeat (3) @(negedge clk);
    chk("run3_done_stop", done_stop, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp_args = '0;
    @(negedge clk);
    chk("midrst_done_stop", done_stop, 1);
    chk("midrst_go", go_valid, 0);
    chk("midrst_args", kargs, exp_args);
    chk("midrst_irq", irq, 0);
    rd(32'h00, 32'h4, "ctrl_midrst");

    repeat (3) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
